mem_march_bist: RTL and testbench

March C- built-in self-test controller for the DLX read/write data memory. It sits directly upstream of the DRAM model and drives its request port in place of the core's load/store unit during test. It walks the full configured address range and checks every read against the expected background. It stops on the first mismatch or timeout and reports the failing address, element, data and expected data.

---
 rtl/mem_march_bist.sv | 185 ++++++++++++++++++
 tb/tb_mem_march_bist.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_march_bist.sv
// rtl/mem_march_bist.sv - March C- self-test controller for the data memory request port
// Walks M0..M5 over NUM_WORDS words and reports the first read mismatch or request timeout.
module mem_march_bist #(
   parameter int                        ADDRESS_SIZE   = 32,
   parameter int                        WORD_SIZE      = 32,
   parameter int                        NUM_WORDS      = 1024,
   parameter int                        ADDR_STRIDE    = 4,
   parameter logic [ADDRESS_SIZE-1:0]   BASE_ADDR      = '0,
   parameter int                        TIMEOUT_CYCLES = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic                    timeout,
   output logic [2:0]              fail_element,
   output logic [ADDRESS_SIZE-1:0] fail_addr,
   output logic [WORD_SIZE-1:0]    fail_data,
   output logic [WORD_SIZE-1:0]    fail_expected,
   output logic [ADDRESS_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0]    mem_wdata,
   output logic                    mem_we,
   output logic                    mem_re,
   input  logic [WORD_SIZE-1:0]    mem_rdata,
   input  logic                    mem_ready
);

   localparam int IDX_W = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_NEXT,
      S_DONE
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [2:0]              r_elem;
   logic                    r_op;
   logic [IDX_W-1:0]        r_index;
   logic [TMR_W-1:0]        r_timer;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_pass;
   logic                    r_timeout;
   logic [2:0]              r_fail_element;
   logic [ADDRESS_SIZE-1:0] r_fail_addr;
   logic [WORD_SIZE-1:0]    r_fail_data;
   logic [WORD_SIZE-1:0]    r_fail_expected;

   logic                    w_is_write;
   logic                    w_pattern_one;
   logic [WORD_SIZE-1:0]    w_pattern;
   logic                    w_descend;
   logic                    w_last_op;
   logic                    w_at_end;
   logic [ADDRESS_SIZE-1:0] w_addr;
   logic                    w_req;
   logic                    w_mismatch;
   logic                    w_expire;
   logic                    w_finish;

   // r_op selects the read (0) or write (1) half of the two-operation elements M1..M4.
   always_comb begin
      w_is_write    = (r_elem == 3'd0) || ((r_elem != 3'd5) && r_op);
      w_pattern_one = (((r_elem == 3'd1) || (r_elem == 3'd3)) && r_op) ||
                      (((r_elem == 3'd2) || (r_elem == 3'd4)) && !r_op);
      w_pattern     = w_pattern_one ? '1 : '0;
      w_descend     = (r_elem == 3'd3) || (r_elem == 3'd4);
      w_last_op     = (r_elem == 3'd0) || (r_elem == 3'd5) || r_op;
      w_at_end      = w_descend ? (r_index == '0) : (r_index == LAST_IDX);
      w_addr        = BASE_ADDR + ADDRESS_SIZE'(r_index) * ADDRESS_SIZE'(ADDR_STRIDE);
      w_req         = (r_state == S_ISSUE) || (r_state == S_WAIT);
      w_mismatch    = (r_state == S_WAIT) && mem_ready && !w_is_write &&
                      (mem_rdata != w_pattern);
      w_expire      = (r_state == S_WAIT) && !mem_ready && (r_timer == TMR_LAST);
      w_finish      = (r_state == S_NEXT) && w_last_op && w_at_end && (r_elem == 3'd5);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (w_mismatch || w_expire) w_state_nxt = S_DONE;
            else if (mem_ready)         w_state_nxt = S_NEXT;
         end
         S_NEXT:  w_state_nxt = w_finish ? S_DONE : S_ISSUE;
         S_DONE:  if (start) w_state_nxt = S_ISSUE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state         <= S_IDLE;
         r_elem          <= '0;
         r_op            <= 1'b0;
         r_index         <= '0;
         r_timer         <= '0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_pass          <= 1'b0;
         r_timeout       <= 1'b0;
         r_fail_element  <= '0;
         r_fail_addr     <= '0;
         r_fail_data     <= '0;
         r_fail_expected <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_elem          <= '0;
                  r_op            <= 1'b0;
                  r_index         <= '0;
                  r_busy          <= 1'b1;
                  r_done          <= 1'b0;
                  r_pass          <= 1'b0;
                  r_timeout       <= 1'b0;
                  r_fail_element  <= '0;
                  r_fail_addr     <= '0;
                  r_fail_data     <= '0;
                  r_fail_expected <= '0;
               end
            end
            S_ISSUE: r_timer <= '0;
            S_WAIT: begin
               r_timer <= r_timer + TMR_W'(1);
               if (w_mismatch || w_expire) begin
                  r_busy          <= 1'b0;
                  r_done          <= 1'b1;
                  r_pass          <= 1'b0;
                  r_timeout       <= w_expire;
                  r_fail_element  <= r_elem;
                  r_fail_addr     <= w_addr;
                  r_fail_data     <= w_expire ? '0 : mem_rdata;
                  r_fail_expected <= w_pattern;
               end
            end
            S_NEXT: begin
               if (!w_last_op) begin
                  r_op <= 1'b1;
               end else begin
                  r_op <= 1'b0;
                  if (w_finish) begin
                     r_busy <= 1'b0;
                     r_done <= 1'b1;
                     r_pass <= 1'b1;
                  end else if (w_at_end) begin
                     // M3 and M4 descend, so they start from the top word.
                     r_elem  <= r_elem + 3'd1;
                     r_index <= ((r_elem == 3'd2) || (r_elem == 3'd3)) ? LAST_IDX : '0;
                  end else begin
                     r_index <= w_descend ? (r_index - IDX_W'(1)) : (r_index + IDX_W'(1));
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy          = r_busy;
   assign done          = r_done;
   assign pass          = r_pass;
   assign timeout       = r_timeout;
   assign fail_element  = r_fail_element;
   assign fail_addr     = r_fail_addr;
   assign fail_data     = r_fail_data;
   assign fail_expected = r_fail_expected;
   assign mem_we        = w_req && w_is_write;
   assign mem_re        = w_req && !w_is_write;
   assign mem_addr      = w_req ? w_addr : '0;
   assign mem_wdata     = (w_req && w_is_write) ? w_pattern : '0;

endmodule

// File: tb/tb_mem_march_bist.sv
// tb/tb_mem_march_bist.sv - directed bench for mem_march_bist with a two-cycle memory model
module tb_mem_march_bist;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy, done, pass, timeout;
   logic [2:0]    fail_element;
   logic [AW-1:0] fail_addr;
   logic [DW-1:0] fail_data, fail_expected;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we, mem_re;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;

   always #5 clk = ~clk;

   mem_march_bist #(
      .ADDRESS_SIZE(AW), .WORD_SIZE(DW), .NUM_WORDS(NW), .ADDR_STRIDE(4),
      .BASE_ADDR('0), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
      .timeout(timeout), .fail_element(fail_element), .fail_addr(fail_addr),
      .fail_data(fail_data), .fail_expected(fail_expected), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   // Memory model: ready in the second cycle after the request first appears.
   logic [DW-1:0] mem [NW];
   int            cnt = 0;
   bit            stuck_fault = 0;
   bit            ignore_fault = 0;
   bit            both_seen = 0;
   int            ops = 0;
   logic [AW-1:0] op_addr  [100];
   logic          op_we    [100];
   logic [DW-1:0] op_wdata [100];
   logic          req;
   logic [2:0]    widx;

   assign req       = mem_re | mem_we;
   assign widx      = mem_addr[4:2];
   assign mem_ready = req && (cnt == 3) && !(ignore_fault && (mem_addr == 32'h10));
   assign mem_rdata = mem_re ? (mem[widx] | ((stuck_fault && (mem_addr == 32'hC)) ? 32'h8 : 32'h0))
                             : '0;

   always @(negedge clk) begin
      if (mem_re && mem_we) both_seen = 1;
      if (req) cnt = cnt + 1;
      else     cnt = 0;
      if (req && (cnt == 3) && !(ignore_fault && (mem_addr == 32'h10))) begin
         if (ops < 100) begin
            op_addr[ops]  = mem_addr;
            op_we[ops]    = mem_we;
            op_wdata[ops] = mem_wdata;
         end
         ops = ops + 1;
         if (mem_we) mem[widx] = mem_wdata;
      end
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_busy"},      64'(busy), 64'd0);
      check({pfx, "_done"},      64'(done), 64'd0);
      check({pfx, "_pass"},      64'(pass), 64'd0);
      check({pfx, "_timeout"},   64'(timeout), 64'd0);
      check({pfx, "_felem"},     64'(fail_element), 64'd0);
      check({pfx, "_faddr"},     64'(fail_addr), 64'd0);
      check({pfx, "_fdata"},     64'(fail_data), 64'd0);
      check({pfx, "_fexp"},      64'(fail_expected), 64'd0);
      check({pfx, "_mem_addr"},  64'(mem_addr), 64'd0);
      check({pfx, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
      check({pfx, "_mem_we"},    64'(mem_we), 64'd0);
      check({pfx, "_mem_re"},    64'(mem_re), 64'd0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int cyc0, output int cyc);
      cyc = cyc0;
      while (!done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check("done_within_bound", 64'(done), 64'd1);
   endtask

   task automatic check_good_run(input string pfx, input int cyc);
      check({pfx, "_cycles"},  64'(cyc), 64'd320);
      check({pfx, "_pass"},    64'(pass), 64'd1);
      check({pfx, "_timeout"}, 64'(timeout), 64'd0);
      check({pfx, "_busy"},    64'(busy), 64'd0);
      check({pfx, "_felem"},   64'(fail_element), 64'd0);
      check({pfx, "_faddr"},   64'(fail_addr), 64'd0);
      check({pfx, "_fdata"},   64'(fail_data), 64'd0);
      check({pfx, "_fexp"},    64'(fail_expected), 64'd0);
      check({pfx, "_ops"},     64'(ops), 64'd80);
   endtask

   initial begin
      int cyc;
      int bad;
      int snap;
      int w;
      for (int i = 0; i < NW; i++) mem[i] = 32'h5A5A5A5A;
      rst   = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b1;
      @(negedge clk);

      // Good run with a stray start pulse while busy.
      ops = 0;
      pulse_start();
      check("busy_after_start", 64'(busy), 64'd1);
      repeat (49) @(negedge clk);
      pulse_start();
      wait_done(50, cyc);
      check_good_run("good", cyc);
      check("m0_first_addr", 64'(op_addr[0]), 64'h0);
      check("m3_first_addr", 64'(op_addr[40]), 64'h1C);
      check("m3_first_is_read", 64'(op_we[40]), 64'd0);
      check("m4_last_read_addr", 64'(op_addr[70]), 64'h0);
      check("m5_last_addr", 64'(op_addr[79]), 64'h1C);
      check("m5_last_is_read", 64'(op_we[79]), 64'd0);
      bad = 0;
      for (int k = 9; k < 24; k += 2)
         if (!op_we[k] || op_wdata[k] !== 32'hFFFFFFFF) bad++;
      for (int k = 41; k < 56; k += 2)
         if (!op_we[k] || op_wdata[k] !== 32'hFFFFFFFF) bad++;
      check("ones_writes_m1_m3", 64'(bad), 64'd0);
      check("never_we_and_re", 64'(both_seen), 64'd0);

      // Stuck-at-1 on bit 3 of word 0x0C.
      stuck_fault = 1;
      ops = 0;
      pulse_start();
      wait_done(0, cyc);
      check("stuck_cycles",  64'(cyc), 64'd59);
      check("stuck_pass",    64'(pass), 64'd0);
      check("stuck_timeout", 64'(timeout), 64'd0);
      check("stuck_felem",   64'(fail_element), 64'd1);
      check("stuck_faddr",   64'(fail_addr), 64'hC);
      check("stuck_fdata",   64'(fail_data), 64'h8);
      check("stuck_fexp",    64'(fail_expected), 64'h0);
      repeat (10) @(negedge clk);
      check("stuck_ops_frozen", 64'(ops), 64'd15);
      check("stuck_no_req", 64'(req), 64'd0);

      // Restart from a failed DONE clears results and reruns fully.
      stuck_fault = 0;
      ops = 0;
      pulse_start();
      check("rerun_done_clr",  64'(done), 64'd0);
      check("rerun_busy",      64'(busy), 64'd1);
      check("rerun_felem_clr", 64'(fail_element), 64'd0);
      check("rerun_faddr_clr", 64'(fail_addr), 64'd0);
      check("rerun_fdata_clr", 64'(fail_data), 64'd0);
      wait_done(0, cyc);
      check_good_run("rerun", cyc);

      // Memory never answers at 0x10.
      ignore_fault = 1;
      ops = 0;
      pulse_start();
      wait_done(0, cyc);
      check("to_cycles",  64'(cyc), 64'd81);
      check("to_pass",    64'(pass), 64'd0);
      check("to_timeout", 64'(timeout), 64'd1);
      check("to_felem",   64'(fail_element), 64'd0);
      check("to_faddr",   64'(fail_addr), 64'h10);
      check("to_fdata",   64'(fail_data), 64'h0);
      check("to_ops",     64'(ops), 64'd4);
      ignore_fault = 0;

      // Reset during M2, then a fresh run.
      ops = 0;
      pulse_start();
      w = 0;
      while (ops < 30 && w < 500) begin
         @(negedge clk);
         w++;
      end
      check("reached_m2", 64'(ops >= 30), 64'd1);
      rst = 1'b0;
      @(negedge clk);
      check_zero("midrst");
      snap = ops;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check("midrst_no_ops", 64'(ops), 64'(snap));
      check("midrst_idle_req", 64'(req), 64'd0);
      ops = 0;
      pulse_start();
      wait_done(0, cyc);
      check_good_run("postrst", cyc);
      check("postrst_first_addr", 64'(op_addr[0]), 64'h0);
      check("postrst_first_we", 64'(op_we[0]), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
